// File: rtl/seq_pkg.sv
// Shared definitions for the serial bit-sequence path (generator and detector).
//   state_t  : FSM state encoding shared by both ends of the path
//   PAT_0101 : default 4-bit pattern that the detector looks for
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [3:0] PAT_0101 = 4'b0101;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register, MSB first.
//   clock : rising-edge clock
//   reset : asynchronous active-low clear
//   load  : parallel load of din (takes priority over shift)
//   shift : shift left by one, zero enters at the LSB
//   din   : parallel data
//   msb   : current MSB (serial output)
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Serial pattern generator: shifts a WIDTH-bit pattern out MSB first, one bit
// per clock, repeated back-to-back repeat_count times, then pulses done.
// Moore machine: outputs are decoded from the state and datapath registers only.
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   start        : transfer request, sampled only in IDLE
//   pattern      : pattern to send, captured when start is accepted
//   repeat_count : number of repetitions, captured when start is accepted
//   out          : serial data bit
//   out_valid    : out carries a pattern bit
//   busy         : transfer in progress (SHIFT or DONE)
//   done         : one-cycle pulse after the final bit
module moore_seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int REPEAT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [REPEAT_W-1:0] repeat_count,
  output logic                out,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]    BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]    BIT_ONE  = CNT_W'(1);
  localparam logic [REPEAT_W-1:0] REP_ONE  = REPEAT_W'(1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [REPEAT_W-1:0] rep_cnt, rep_cnt_d;
  logic [WIDTH-1:0]    pattern_q, pattern_d;
  logic                sh_load, sh_shift, sh_msb;
  logic [WIDTH-1:0]    sh_din;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clock (clock),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      pattern_q <= '0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      rep_cnt   <= rep_cnt_d;
      pattern_q <= pattern_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    rep_cnt_d = rep_cnt;
    pattern_d = pattern_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_din    = pattern_q;
    case (state)
      IDLE: begin
        if (start) begin
          sh_load   = 1'b1;
          sh_din    = pattern;
          pattern_d = pattern;
          rep_cnt_d = repeat_count;
          bit_cnt_d = BIT_LAST;
          // A zero repeat count skips straight to the done pulse.
          state_d   = (repeat_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (rep_cnt > REP_ONE) begin
            // Reload in the same edge so repetitions run with no gap.
            sh_load   = 1'b1;
            bit_cnt_d = BIT_LAST;
            rep_cnt_d = rep_cnt - REP_ONE;
          end else begin
            sh_shift = 1'b1;
            state_d  = DONE;
          end
        end else begin
          sh_shift  = 1'b1;
          bit_cnt_d = bit_cnt - BIT_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state == SHIFT);
  assign out       = (state == SHIFT) & sh_msb;
  assign busy      = (state == SHIFT) | (state == DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed bench for moore_seq_gen (WIDTH=4, REPEAT_W=4).
module tb_moore_seq_gen;
  import seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeat_count;
  logic       out, out_valid, busy, done;

  int passed = 0;
  int total  = 0;

  logic [3:0] win;
  int         nvalid;
  int         dets;

  moore_seq_gen #(.WIDTH(4), .REPEAT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .pattern      (pattern),
    .repeat_count (repeat_count),
    .out          (out),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Outputs packed as {out_valid, out, busy, done}.
  function automatic logic [31:0] outs();
    return 32'({out_valid, out, busy, done});
  endfunction

  // Called at the negedge of the first SHIFT cycle; returns at the negedge of the DONE cycle.
  task automatic expect_stream(input string tag, input int n, input logic [63:0] exp);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), outs(), 32'({1'b1, exp[n-1-i], 1'b1, 1'b0}));
      if (out_valid) begin
        win = {win[2:0], out};
        nvalid++;
        if (nvalid >= 4 && win == 4'b0101) dets++;
      end
      @(negedge clock);
    end
    chk({tag, "_done"}, outs(), 32'b0011);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pattern = 4'h0; repeat_count = 4'h0;
    win = 4'h0; nvalid = 0; dets = 0;

    // Reset state
    #2 chk("reset_outs", outs(), 32'b0000);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_after_reset", outs(), 32'b0000);

    // Single copy of 0101
    pattern = PAT_0101; repeat_count = 4'd1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    expect_stream("rep1", 4, 64'h5);
    @(negedge clock);
    chk("rep1_idle", outs(), 32'b0000);

    // Three back-to-back copies with window counting
    win = 4'h0; nvalid = 0; dets = 0;
    pattern = PAT_0101; repeat_count = 4'd3; start = 1'b1;
    @(negedge clock); start = 1'b0;
    expect_stream("rep3", 12, 64'h555);
    chk("rep3_windows", 32'(dets), 32'd5);
    @(negedge clock);
    chk("rep3_idle", outs(), 32'b0000);

    // Zero repeat: straight to done
    pattern = 4'b1010; repeat_count = 4'd0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("rep0_done", outs(), 32'b0011);
    @(negedge clock);
    chk("rep0_idle", outs(), 32'b0000);

    // Start re-pulsed and inputs changed mid-transfer, then start held through DONE
    pattern = 4'b1100; repeat_count = 4'd1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("hold_b0", outs(), 32'b1110);
    @(negedge clock);
    start = 1'b1; pattern = 4'b0011; repeat_count = 4'd2;
    chk("hold_b1", outs(), 32'b1110);
    @(negedge clock); start = 1'b0;
    chk("hold_b2", outs(), 32'b1010);
    @(negedge clock); start = 1'b1;
    chk("hold_b3", outs(), 32'b1010);
    @(negedge clock);
    chk("hold_done", outs(), 32'b0011);
    @(negedge clock);
    chk("hold_idle_gap", outs(), 32'b0000);
    @(negedge clock); start = 1'b0;
    expect_stream("second", 8, 64'h33);
    @(negedge clock);
    chk("second_idle", outs(), 32'b0000);

    // Maximum repeat count: 15 copies of 1001
    pattern = 4'b1001; repeat_count = 4'hF; start = 1'b1;
    @(negedge clock); start = 1'b0;
    expect_stream("rep15", 60, 64'h0999_9999_9999_9999);
    @(negedge clock);
    chk("rep15_idle", outs(), 32'b0000);

    // Asynchronous reset in the middle of a transfer
    pattern = 4'b1111; repeat_count = 4'd2; start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("rst_pre_b0", outs(), 32'b1110);
    @(negedge clock); @(negedge clock);
    chk("rst_pre_b2", outs(), 32'b1110);
    #2 reset = 1'b0;
    #1 chk("rst_async", outs(), 32'b0000);
    @(negedge clock);
    chk("rst_hold1", outs(), 32'b0000);
    @(negedge clock);
    chk("rst_hold2", outs(), 32'b0000);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rst_release%0d", i), outs(), 32'b0000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
